// File: rtl/muntjac_mul_arbiter.sv
// muntjac_mul_arbiter: round-robin sharing of one iterative multiplier among NumReq requesters.
// Winner operands pass straight through; the response pulse is steered back to the op's owner.
module muntjac_mul_arbiter #(
    parameter int unsigned NumReq = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq-1:0][63:0] req_a_i,
    input  logic [NumReq-1:0][63:0] req_b_i,
    input  logic [NumReq-1:0][1:0]  req_op_i,
    input  logic [NumReq-1:0]       req_word_i,
    input  logic [NumReq-1:0]       req_kill_i,
    output logic [NumReq-1:0]       resp_valid_o,
    output logic [63:0]             resp_value_o,
    output logic                    mul_req_valid_o,
    input  logic                    mul_req_ready_i,
    output logic [63:0]             mul_a_o,
    output logic [63:0]             mul_b_o,
    output logic [1:0]              mul_op_o,
    output logic                    mul_word_o,
    input  logic                    mul_resp_valid_i,
    input  logic [63:0]             mul_resp_value_i
);

    localparam int unsigned IdxW = $clog2(NumReq);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e          r_state;
    logic [IdxW-1:0] r_rr_ptr;
    logic [IdxW-1:0] r_owner;
    logic            r_killed;

    logic            w_can_issue;
    logic            w_accept;
    logic            w_resp;
    logic            w_found;
    logic [IdxW-1:0] w_winner;

    // Scan starting at the round-robin pointer; the first valid requester wins.
    always_comb begin : p_winner
        int unsigned v_idx;
        v_idx    = '0;
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        for (int unsigned k = 0; k < NumReq; k++) begin
            v_idx = {{(32-IdxW){1'b0}}, r_rr_ptr} + k;
            if (v_idx >= NumReq) begin
                v_idx = v_idx - NumReq;
            end
            if (!w_found && req_valid_i[IdxW'(v_idx)]) begin
                w_found  = 1'b1;
                w_winner = IdxW'(v_idx);
            end
        end
    end

    // A new op may issue in the same cycle the previous one responds.
    assign w_can_issue = !rst_i && mul_req_ready_i &&
                         ((r_state == ST_IDLE) || ((r_state == ST_BUSY) && mul_resp_valid_i));
    assign mul_req_valid_o = w_can_issue && (|req_valid_i);
    assign w_accept        = mul_req_valid_o && mul_req_ready_i;
    assign w_resp          = !rst_i && (r_state == ST_BUSY) && mul_resp_valid_i;

    assign mul_a_o      = req_a_i[w_winner];
    assign mul_b_o      = req_b_i[w_winner];
    assign mul_op_o     = req_op_i[w_winner];
    assign mul_word_o   = req_word_i[w_winner];
    assign resp_value_o = mul_resp_value_i;

    always_comb begin
        req_ready_o = '0;
        if (mul_req_valid_o && w_found) begin
            req_ready_o[w_winner] = 1'b1;
        end
    end

    // A kill arriving in the response cycle suppresses the pulse without touching r_killed.
    always_comb begin
        resp_valid_o = '0;
        if (w_resp && !r_killed && !req_kill_i[r_owner]) begin
            resp_valid_o[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_killed <= 1'b0;
        end else if (w_accept) begin
            r_state  <= ST_BUSY;
            r_owner  <= w_winner;
            r_killed <= 1'b0;
            r_rr_ptr <= (w_winner == IdxW'(NumReq - 1)) ? '0 : w_winner + 1'b1;
        end else if (r_state == ST_BUSY) begin
            if (mul_resp_valid_i) begin
                r_state  <= ST_IDLE;
                r_killed <= 1'b0;
            end else if (req_kill_i[r_owner]) begin
                r_killed <= 1'b1;
            end
        end
    end

    // A response with nothing in flight means the multiplier and arbiter lost sync.
    a_no_stray_resp: assert property (@(posedge clk_i) disable iff (rst_i)
        !((r_state == ST_IDLE) && mul_resp_valid_i));

endmodule
